eluks_wb_slave: RTL

// Wishbone slave front-end of the ELUKS decryptor; the bus target of the boot loader's ELUKS_WB_ADDR window.

---
 rtl/eluks_wb_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/eluks_wb_slave.sv
// eluks_wb_slave: Wishbone register window, header handshake and block-stream byte FIFO for the ELUKS decryptor
module eluks_wb_slave #(
  parameter int          WB_DATA    = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h92000000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          BLK_BYTES  = 512
) (
  input  logic               wb_clk,
  input  logic               rst_n,
  input  logic [31:0]        wb_adr_i,
  input  logic [WB_DATA-1:0] wb_dat_i,
  input  logic               wb_we_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic [3:0]         wb_sel_i,
  output logic [WB_DATA-1:0] wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [63:0]        core_psw,
  output logic [31:0]        core_start_blk,
  output logic               core_hmac_en,
  output logic               hdr_rq,
  input  logic               hdr_done,
  input  logic [31:0]        hdr_status,
  output logic               blk_rq,
  output logic [31:0]        blk_num,
  input  logic               blk_ack,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BLK_BYTES);
  typedef enum logic [1:0] {W_IDLE, W_HDR, W_DATA, W_ACK} w_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_RECV, F_DONE} f_t;
  w_t ws, ws_n;
  f_t fs, fs_n;
  logic [31:0] off, rd_val, psw0, psw1, start_blk, blk_dir, status, k;
  logic hmac, acc, acc_stat, acc_data, hdr_ack, rsp, empty, full, exh, push, pop, last;
  logic [BW-1:0] bcnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic unused_ok;
  assign off = wb_adr_i - BASE_ADDR;
  assign acc = ws == W_IDLE && wb_cyc_i && wb_stb_i;
  assign acc_stat = acc && off == 32'd6;
  assign acc_data = (acc && off == 32'd5) || (ws == W_DATA && wb_cyc_i);
  assign hdr_ack = ws == W_HDR && wb_cyc_i && hdr_done;
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(FIFO_DEPTH);
  assign exh = empty && fs == F_DONE;
  assign pop = acc_data && !empty;
  assign push = fs == F_RECV && s_valid && !full;
  assign last = push && bcnt == BW'(BLK_BYTES - 1);
  // a response is registered this cycle and shows as a one-cycle ack on the next
  assign rsp = (acc && off != 32'd5 && off != 32'd6) || hdr_ack || (acc_data && (!empty || exh));
  assign rd_val = off == 32'd0 ? psw0 : off == 32'd1 ? psw1 : off == 32'd2 ? start_blk :
                  off == 32'd3 ? blk_dir : off == 32'd4 ? {31'h0, hmac} : 32'h0;
  assign wb_err_o = 1'b0;
  assign core_psw = {psw0, psw1};
  assign core_start_blk = start_blk;
  assign core_hmac_en = hmac;
  assign blk_rq = fs == F_REQ;
  assign blk_num = blk_dir + k;
  assign s_ready = !full;
  assign unused_ok = ^{wb_sel_i, status[31]};
  always_comb begin
    ws_n = ws;
    if (rsp) ws_n = W_ACK;
    else if (acc_stat) ws_n = W_HDR;
    else if (acc) ws_n = W_DATA;
    else if ((ws == W_HDR || ws == W_DATA) && !wb_cyc_i) ws_n = W_IDLE;
    else if (ws == W_ACK && !wb_stb_i) ws_n = W_IDLE;
  end
  always_comb begin
    fs_n = fs;
    if (acc_stat) fs_n = F_IDLE;
    else if (fs == F_IDLE && hdr_done) fs_n = (hdr_status[31] || hdr_status[30:0] == 31'd0) ? F_DONE : F_REQ;
    else if (fs == F_REQ && blk_ack) fs_n = F_RECV;
    else if (last) fs_n = k + 32'd1 == {1'b0, status[30:0]} ? F_DONE : F_REQ;
  end
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      ws <= W_IDLE;
      fs <= F_IDLE;
      k <= '0;
      bcnt <= '0;
    end else begin
      ws <= ws_n;
      fs <= fs_n;
      k <= acc_stat ? 32'd0 : last ? k + 32'd1 : k;
      bcnt <= (acc_stat || last) ? '0 : push ? bcnt + 1'b1 : bcnt;
    end
  end
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      psw0 <= '0;
      psw1 <= '0;
      start_blk <= '0;
      blk_dir <= '0;
      hmac <= 1'b0;
      status <= '0;
      wb_dat_o <= '0;
      wb_ack_o <= 1'b0;
      hdr_rq <= 1'b0;
    end else begin
      wb_ack_o <= rsp;
      hdr_rq <= acc_stat;
      if (hdr_done) status <= hdr_status;
      if (rsp) wb_dat_o <= hdr_ack ? hdr_status : acc_data ? {24'h0, empty ? 8'h0 : mem[rp]} : rd_val;
      if (acc && wb_we_i && off == 32'd0) psw0 <= wb_dat_i;
      if (acc && wb_we_i && off == 32'd1) psw1 <= wb_dat_i;
      if (acc && wb_we_i && off == 32'd2) start_blk <= wb_dat_i;
      if (acc && wb_we_i && off == 32'd3) blk_dir <= wb_dat_i;
      if (acc && wb_we_i && off == 32'd4) hmac <= wb_dat_i[0];
    end
  end
  always_ff @(posedge wb_clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else if (acc_stat) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge wb_clk)
    if (push) mem[wp] <= s_data;
endmodule
